// File: rtl/burst_ram_pkg.sv
// Shared definitions for the burst RAM model: FSM encoding, command codes
// and the byte-mask merge used on every write beat.
package burst_ram_pkg;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_RD_WAIT    = 3'd1;
   localparam logic [2:0] ST_RD_BURST   = 3'd2;
   localparam logic [2:0] ST_WR_BURST   = 3'd3;
   localparam logic [2:0] ST_WR_RECOVER = 3'd4;
   localparam logic [2:0] ST_REFRESH    = 3'd5;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   // Widest word the merge helper handles; callers zero-extend and truncate.
   localparam int MAX_DATA_W = 1024;
   localparam int MAX_MASK_W = MAX_DATA_W / 8;

   // Mask bit 1 keeps the old byte, 0 takes the new one.
   function automatic logic [MAX_DATA_W-1:0] mask_merge(
      input logic [MAX_DATA_W-1:0] old_word,
      input logic [MAX_DATA_W-1:0] new_word,
      input logic [MAX_MASK_W-1:0] mask
   );
      logic [MAX_DATA_W-1:0] merged;
      merged = '0;
      for (int b = 0; b < MAX_MASK_W; b++)
         merged[b*8 +: 8] = mask[b] ? old_word[b*8 +: 8] : new_word[b*8 +: 8];
      return merged;
   endfunction

endpackage

// File: rtl/burst_ram_refresh_timer.sv
// Free-running refresh interval counter; raises refresh_pending once per
// REFRESH_INTERVAL cycles and drops it when the controller takes the refresh.
module burst_ram_refresh_timer #(
   parameter int REFRESH_INTERVAL = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic take,
   output logic refresh_pending
);

   localparam int CNT_W = $clog2(REFRESH_INTERVAL) + 1;

   logic [CNT_W-1:0] interval_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         interval_cnt    <= '0;
         refresh_pending <= 1'b0;
      end else begin
         if (take)
            refresh_pending <= 1'b0;
         // A new request landing on the take edge is kept, not lost.
         if (interval_cnt == CNT_W'(REFRESH_INTERVAL - 1)) begin
            interval_cnt    <= '0;
            refresh_pending <= 1'b1;
         end else begin
            interval_cnt <= interval_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/burst_ram_model.sv
// Bursting external RAM model with byte masks, address wrap and command-error
// flag. Define BURST_RAM_REFRESH_EN to enable periodic refresh stalls.
module burst_ram_model
   import burst_ram_pkg::*;
#(
   parameter int    DEPTH_BITWIDTH   = 4,
   parameter int    DATA_BITWIDTH    = 64,
   parameter int    BURST_LENGTH     = 4,
   parameter int    READ_LATENCY     = 8,
   parameter int    WRITE_RECOVERY   = 0,
   parameter string DATA_FILE        = "",
   parameter int    REFRESH_INTERVAL = 64,
   parameter int    REFRESH_CYCLES   = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cmd,
   input  logic                       cmd_en,
   input  logic [DEPTH_BITWIDTH-1:0]  addr,
   input  logic [DATA_BITWIDTH-1:0]   wr_data,
   input  logic [DATA_BITWIDTH/8-1:0] data_mask,
   output logic [DATA_BITWIDTH-1:0]   rd_data,
   output logic                       rd_data_valid,
   output logic                       busy,
   output logic                       cmd_err
);

   localparam int DEPTH = 2 ** DEPTH_BITWIDTH;
   localparam int CNT_W = 16;
   localparam logic [DEPTH_BITWIDTH-1:0] ADDR_ONE = DEPTH_BITWIDTH'(1);
   localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);

   logic [DATA_BITWIDTH-1:0]  mem [DEPTH];
   logic [2:0]                state;
   logic [CNT_W-1:0]          cnt;
   logic [DEPTH_BITWIDTH-1:0] burst_addr;
   logic                      take_refresh;
   logic                      accept;
   logic                      wr_en;
   logic [DEPTH_BITWIDTH-1:0] wr_addr;
   logic [DATA_BITWIDTH-1:0]  wr_word;

`ifdef BURST_RAM_REFRESH_EN
   logic refresh_pending;

   burst_ram_refresh_timer #(
      .REFRESH_INTERVAL (REFRESH_INTERVAL)
   ) u_refresh_timer (
      .clk             (clk),
      .rst_n           (rst_n),
      .take            (take_refresh),
      .refresh_pending (refresh_pending)
   );

   assign take_refresh = (state == ST_IDLE) && refresh_pending;
`else
   assign take_refresh = 1'b0;
`endif

   assign busy   = (state != ST_IDLE);
   assign accept = cmd_en && (state == ST_IDLE) && !busy && !take_refresh;

   // Beat 0 of a write lands on the accept edge, using the incoming address.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = burst_addr;
      if (accept && (cmd == CMD_WRITE)) begin
         wr_en   = rst_n;
         wr_addr = addr;
      end else if (state == ST_WR_BURST) begin
         wr_en   = rst_n;
      end
   end

   assign wr_word = DATA_BITWIDTH'(mask_merge(MAX_DATA_W'(mem[wr_addr]),
                                              MAX_DATA_W'(wr_data),
                                              MAX_MASK_W'(data_mask)));

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         burst_addr    <= '0;
         rd_data       <= '0;
         rd_data_valid <= 1'b0;
         cmd_err       <= 1'b0;
      end else begin
         cmd_err <= cmd_en && !accept;
         case (state)
            ST_IDLE: begin
               if (take_refresh) begin
                  state <= ST_REFRESH;
                  cnt   <= '0;
               end else if (accept) begin
                  cnt <= CNT_ONE;
                  if (cmd == CMD_WRITE) begin
                     state      <= ST_WR_BURST;
                     burst_addr <= addr + ADDR_ONE;
                  end else if (READ_LATENCY == 1) begin
                     state         <= ST_RD_BURST;
                     rd_data       <= mem[addr];
                     rd_data_valid <= 1'b1;
                     burst_addr    <= addr + ADDR_ONE;
                  end else begin
                     state      <= ST_RD_WAIT;
                     burst_addr <= addr;
                  end
               end
            end
            // cnt counts edges since accept; the first beat is registered one
            // edge early so it is visible at accept + READ_LATENCY.
            ST_RD_WAIT: begin
               if (cnt == CNT_W'(READ_LATENCY - 1)) begin
                  state         <= ST_RD_BURST;
                  rd_data       <= mem[burst_addr];
                  rd_data_valid <= 1'b1;
                  burst_addr    <= burst_addr + ADDR_ONE;
                  cnt           <= CNT_ONE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            ST_RD_BURST: begin
               if (cnt == CNT_W'(BURST_LENGTH)) begin
                  state         <= ST_IDLE;
                  rd_data_valid <= 1'b0;
                  cnt           <= '0;
               end else begin
                  rd_data    <= mem[burst_addr];
                  burst_addr <= burst_addr + ADDR_ONE;
                  cnt        <= cnt + CNT_ONE;
               end
            end
            ST_WR_BURST: begin
               burst_addr <= burst_addr + ADDR_ONE;
               if (cnt == CNT_W'(BURST_LENGTH - 1)) begin
                  cnt   <= '0;
                  state <= (WRITE_RECOVERY == 0) ? ST_IDLE : ST_WR_RECOVER;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            ST_WR_RECOVER: begin
               if (cnt == CNT_W'(WRITE_RECOVERY - 1)) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            ST_REFRESH: begin
               if (cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_burst_ram_model.sv
// Directed bench for burst_ram_model (defaults, WRITE_RECOVERY = 3).
// Inputs change and outputs are sampled on the falling edge.
module tb_burst_ram_model;

   logic        clk;
   logic        rst_n;
   logic        cmd;
   logic        cmd_en;
   logic [3:0]  addr;
   logic [63:0] wr_data;
   logic [7:0]  data_mask;
   logic [63:0] rd_data;
   logic        rd_data_valid;
   logic        busy;
   logic        cmd_err;

   int checks = 0;
   int errors = 0;

   logic [63:0] wbeat [4];
   logic [7:0]  wmask [4];
   logic [63:0] rbeat [4];
   logic [63:0] exp_b [4];
   int          rfirst;
   int          rnv;
   int          rfall;

   burst_ram_model #(
      .WRITE_RECOVERY (3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd           (cmd),
      .cmd_en        (cmd_en),
      .addr          (addr),
      .wr_data       (wr_data),
      .data_mask     (data_mask),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .busy          (busy),
      .cmd_err       (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, need finish");
      $fatal(1);
   end

   task automatic wait_idle();
      for (int n = 0; n < 40 && busy; n++) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: busy=%b, need 0", busy);
      end
   endtask

   // j0 = edges elapsed since accept at the current falling edge.
   task automatic collect(input int j0);
      int j;
      j      = j0;
      rfirst = -1;
      rnv    = 0;
      rfall  = -1;
      for (int k = 0; k < 4; k++) rbeat[k] = '0;
      for (int n = 0; n < 64; n++) begin
         if (rd_data_valid) begin
            if (rfirst < 0) rfirst = j;
            if (rnv < 4) rbeat[rnv] = rd_data;
            rnv++;
         end
         if (!busy) begin
            rfall = j;
            break;
         end
         @(negedge clk);
         j++;
      end
   endtask

   task automatic write_burst(input logic [3:0] a);
      cmd_en = 1'b1; cmd = 1'b1; addr = a;
      wr_data = wbeat[0]; data_mask = wmask[0];
      @(posedge clk);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         cmd_en = 1'b0; wr_data = wbeat[k]; data_mask = wmask[k];
         @(posedge clk);
      end
      @(negedge clk);
      cmd_en = 1'b0;
      wait_idle();
   endtask

   task automatic read_burst(input logic [3:0] a);
      cmd_en = 1'b1; cmd = 1'b0; addr = a;
      @(posedge clk);
      @(negedge clk);
      cmd_en = 1'b0;
      collect(1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_en = 1'b0; cmd = 1'b0; addr = '0;
      wr_data = '0; data_mask = '0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, need 0", busy); end
      checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, need 0", rd_data_valid); end
      checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data: got %h, need 0", rd_data); end
      checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err: got %b, need 0", cmd_err); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read();
      for (int base = 0; base < 16; base += 4) begin
         for (int k = 0; k < 4; k++) begin
            wbeat[k] = 64'(base + k);
            wmask[k] = 8'h00;
         end
         write_burst(4'(base));
      end
      cmd_en = 1'b1; cmd = 1'b0; addr = 4'd2;
      @(posedge clk);
      @(negedge clk);
      cmd_en = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy_t1: got %b, need 1", busy); end
      collect(1);
      checks++; if (rfirst != 8) begin errors++; $display("FAIL read_first_valid: got T+%0d, need T+8", rfirst); end
      checks++; if (rnv != 4) begin errors++; $display("FAIL read_valid_count: got %0d, need 4", rnv); end
      checks++; if (rfall != 12) begin errors++; $display("FAIL read_busy_fall: got T+%0d, need T+12", rfall); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rbeat[k] !== 64'(2 + k)) begin
            errors++; $display("FAIL read_beat%0d: got %h, need %h", k, rbeat[k], 64'(2 + k));
         end
      end
      checks++; if (rd_data !== 64'd5) begin errors++; $display("FAIL read_hold: got %h, need 5", rd_data); end
   endtask

   task automatic test_busy_violation();
      cmd_en = 1'b1; cmd = 1'b0; addr = 4'd2;
      @(posedge clk);
      @(negedge clk);
      cmd_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      cmd_en = 1'b1; cmd = 1'b1; addr = 4'd2; wr_data = 64'hDEAD_BEEF_DEAD_BEEF; data_mask = 8'h00;
      @(negedge clk);
      cmd_en = 1'b0;
      checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL viol_err_high: got %b, need 1", cmd_err); end
      @(negedge clk);
      checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL viol_err_one_cycle: got %b, need 0", cmd_err); end
      collect(5);
      checks++; if (rfirst != 8) begin errors++; $display("FAIL viol_first_valid: got T+%0d, need T+8", rfirst); end
      checks++; if (rfall != 12) begin errors++; $display("FAIL viol_busy_fall: got T+%0d, need T+12", rfall); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rbeat[k] !== 64'(2 + k)) begin
            errors++; $display("FAIL viol_beat%0d: got %h, need %h", k, rbeat[k], 64'(2 + k));
         end
      end
   endtask

   task automatic test_masked_write();
      wbeat[0] = 64'h1111_1111_1111_1111; wbeat[1] = 64'd6; wbeat[2] = 64'd7; wbeat[3] = 64'd8;
      for (int k = 0; k < 4; k++) wmask[k] = 8'h00;
      write_burst(4'd5);
      for (int k = 0; k < 4; k++) begin
         wbeat[k] = 64'hAAAA_AAAA_AAAA_AAAA;
         wmask[k] = 8'h0F;
      end
      write_burst(4'd4);
      read_burst(4'd4);
      exp_b[0] = 64'hAAAA_AAAA_0000_0004;
      exp_b[1] = 64'hAAAA_AAAA_1111_1111;
      exp_b[2] = 64'hAAAA_AAAA_0000_0006;
      exp_b[3] = 64'hAAAA_AAAA_0000_0007;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rbeat[k] !== exp_b[k]) begin
            errors++; $display("FAIL mask_word%0d: got %h, need %h", 4 + k, rbeat[k], exp_b[k]);
         end
      end
   endtask

   task automatic test_wrap();
      wbeat[0] = 64'hA0A0_A0A0_A0A0_A0A0; wbeat[1] = 64'hB1B1_B1B1_B1B1_B1B1;
      wbeat[2] = 64'hC2C2_C2C2_C2C2_C2C2; wbeat[3] = 64'hD3D3_D3D3_D3D3_D3D3;
      for (int k = 0; k < 4; k++) wmask[k] = 8'h00;
      write_burst(4'd14);
      read_burst(4'd14);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rbeat[k] !== wbeat[k]) begin
            errors++; $display("FAIL wrap_read14_beat%0d: got %h, need %h", k, rbeat[k], wbeat[k]);
         end
      end
      read_burst(4'd0);
      exp_b[0] = wbeat[2]; exp_b[1] = wbeat[3]; exp_b[2] = 64'd2; exp_b[3] = 64'd3;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rbeat[k] !== exp_b[k]) begin
            errors++; $display("FAIL wrap_read0_beat%0d: got %h, need %h", k, rbeat[k], exp_b[k]);
         end
      end
   endtask

   task automatic test_write_recovery();
      for (int k = 0; k < 4; k++) wbeat[k] = 64'h0123_4567_89AB_CDE0 + 64'(k);
      cmd_en = 1'b1; cmd = 1'b1; addr = 4'd0; wr_data = wbeat[0]; data_mask = 8'h00;
      @(posedge clk);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         cmd_en = 1'b0; wr_data = wbeat[k];
         @(posedge clk);
      end
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrrec_busy_t4: got %b, need 1", busy); end
      @(negedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrrec_busy_t6: got %b, need 1", busy); end
      cmd_en = 1'b1; cmd = 1'b0; addr = 4'd0;
      @(negedge clk);
      checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL wrrec_err_t7: got %b, need 1", cmd_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrrec_busy_t7: got %b, need 0", busy); end
      @(negedge clk);
      cmd_en = 1'b0;
      checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL wrrec_err_t8: got %b, need 0", cmd_err); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrrec_accept_t7: busy got %b, need 1", busy); end
      collect(1);
      checks++; if (rfirst != 8) begin errors++; $display("FAIL wrrec_read_first_valid: got T+%0d, need T+8", rfirst); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rbeat[k] !== wbeat[k]) begin
            errors++; $display("FAIL wrrec_beat%0d: got %h, need %h", k, rbeat[k], wbeat[k]);
         end
      end
   endtask

   task automatic test_reset_mid_write();
      for (int k = 0; k < 4; k++) wbeat[k] = 64'hE000_0000_0000_0000 + 64'(k);
      cmd_en = 1'b1; cmd = 1'b1; addr = 4'd8; wr_data = wbeat[0]; data_mask = 8'h00;
      @(posedge clk);
      @(negedge clk);
      cmd_en = 1'b0; wr_data = wbeat[1];
      @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b, need 1", busy); end
      wr_data = wbeat[2];
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b, need 0", busy); end
      checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL rst_async_rd_data: got %h, need 0", rd_data); end
      checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b, need 0", rd_data_valid); end
      checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL rst_async_cmd_err: got %b, need 0", cmd_err); end
      @(posedge clk);
      @(negedge clk);
      wr_data = wbeat[3];
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      read_burst(4'd8);
      exp_b[0] = wbeat[0]; exp_b[1] = wbeat[1]; exp_b[2] = 64'd10; exp_b[3] = 64'd11;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rbeat[k] !== exp_b[k]) begin
            errors++; $display("FAIL rst_word%0d: got %h, need %h", 8 + k, rbeat[k], exp_b[k]);
         end
      end
   endtask

   task automatic test_refresh();
      int hi;
      for (int n = 0; n < 200 && !busy; n++) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL refresh_start: busy got %b, need 1", busy); end
      hi = 0;
      for (int n = 0; n < 20 && busy; n++) begin
         hi++;
         if (hi == 1) begin
            cmd_en = 1'b1; cmd = 1'b0; addr = 4'd0;
         end
         @(negedge clk);
         if (hi == 1) begin
            cmd_en = 1'b0;
            checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL refresh_cmd_err: got %b, need 1", cmd_err); end
         end
      end
      checks++; if (hi != 6) begin errors++; $display("FAIL refresh_busy_cycles: got %0d, need 6", hi); end
      checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL refresh_err_clear: got %b, need 0", cmd_err); end
      read_burst(4'd0);
      checks++; if (rfirst != 8) begin errors++; $display("FAIL refresh_read_first_valid: got T+%0d, need T+8", rfirst); end
      checks++; if (rnv != 4) begin errors++; $display("FAIL refresh_read_count: got %0d, need 4", rnv); end
      checks++; if (rfall != 12) begin errors++; $display("FAIL refresh_read_fall: got T+%0d, need T+12", rfall); end
   endtask

   initial begin
      test_reset();
`ifdef BURST_RAM_REFRESH_EN
      test_refresh();
`else
      test_read();
      test_busy_violation();
      test_masked_write();
      test_wrap();
      test_write_recovery();
      test_reset_mid_write();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
